// File: rtl/rfphoenix_memreq_queue_pkg.sv
// Shared memory-request/response types and queue sizing for the rfPhoenix memory request path.
package rfphoenix_memreq_queue_pkg;

    localparam int unsigned MEMQ_DEPTH = 8;
    localparam int unsigned MEMR_DEPTH = 8;

    localparam int unsigned ADR_W    = 32;
    localparam int unsigned DAT_W    = 32;
    localparam int unsigned RID_W    = 6;
    localparam int unsigned STEP_W   = 3;
    localparam int unsigned THREAD_W = 4;

    typedef enum logic [1:0] {
        MR_LOAD  = 2'd0,
        MR_LOADZ = 2'd1,
        MR_STORE = 2'd2,
        MR_NOP   = 2'd3
    } memop_t;

    typedef enum logic [1:0] {
        byt   = 2'd0,
        wyde  = 2'd1,
        tetra = 2'd2,
        octa  = 2'd3
    } memsz;

    typedef struct packed {
        memop_t              func;
        memsz                sz;
        logic [ADR_W-1:0]    adr;
        logic [DAT_W-1:0]    dat;
        logic [RID_W-1:0]    rid;
        logic [STEP_W-1:0]   step;
        logic [THREAD_W-1:0] thread;
    } sMemoryRequest;

    typedef struct packed {
        logic [RID_W-1:0]  rid;
        logic [STEP_W-1:0] step;
        logic [DAT_W-1:0]  dat;
    } sMemoryResponse;

    function automatic logic thread_match(input sMemoryRequest r, input logic [THREAD_W-1:0] t);
        return r.thread == t;
    endfunction

endpackage

// File: rtl/rfphoenix_fwft_fifo.sv
// Generic first-word-fall-through FIFO with sticky overflow flag; a pop frees room for a
// same-cycle push.
module rfphoenix_fwft_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CntFull = CW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             pop_ok, push_ok;

    always_comb begin
        pop_ok  = pop_i && (cnt_q != '0);
        push_ok = push_i && ((cnt_q != CntFull) || pop_ok);
        ovf_d   = ovf_q || (push_i && !push_ok);
        rd_d    = pop_ok ? rd_q + AW'(1) : rd_q;
        wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CntFull);
    assign empty_o = (cnt_q == '0);
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/rfphoenix_memreq_queue.sv
// Memory request queue between execute and the BIU, with per-thread cancellation of
// not-yet-issued requests, plus a FWFT response FIFO back to the core.
module rfphoenix_memreq_queue
    import rfphoenix_memreq_queue_pkg::*;
#(
    parameter int unsigned QDEPTH = MEMQ_DEPTH,
    parameter int unsigned RDEPTH = MEMR_DEPTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  sMemoryRequest       req_i,
    input  logic                req_wr_i,
    output logic                req_full_o,
    output logic                req_wack_o,
    input  logic                flush_i,
    input  logic [THREAD_W-1:0] flush_thread_i,
    output sMemoryRequest       biu_req_o,
    output logic                biu_v_o,
    input  logic                biu_rdy_i,
    input  sMemoryResponse      biu_resp_i,
    input  logic                biu_resp_wr_i,
    output sMemoryResponse      resp_o,
    output logic                resp_v_o,
    output logic                resp_empty_o,
    input  logic                resp_rd_i,
    output logic                ovf_o
);

    localparam int unsigned QAW = $clog2(QDEPTH);
    localparam int unsigned CW  = QAW + 1;
    localparam logic [CW-1:0] CntFull   = CW'(QDEPTH);
    localparam logic [CW-1:0] CntAlmost = CW'(QDEPTH - 1);
    localparam int unsigned RESP_W = $bits(sMemoryResponse);

    sMemoryRequest       req_mem_q [QDEPTH];
    logic [QDEPTH-1:0]   live_q, live_d;
    logic [QDEPTH-1:0]   flush_hit;
    logic [QAW-1:0]      head_q, head_d;
    logic [QAW-1:0]      tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic                wack_q;

    logic                wr_ok;
    logic                wr_cancel;
    logic                q_nonempty;
    logic                head_live;
    logic                head_valid;
    logic                q_pop;

    for (genvar g = 0; g < QDEPTH; g++) begin : g_flush_hit
        assign flush_hit[g] = flush_i && thread_match(req_mem_q[g], flush_thread_i);
    end

    always_comb begin
        wr_ok      = req_wr_i && (count_q != CntFull);
        wr_cancel  = flush_i && thread_match(req_i, flush_thread_i);
        q_nonempty = (count_q != '0);
        head_live  = live_q[head_q];
        head_valid = q_nonempty && head_live;
        // Cancelled heads are dropped in a cycle of their own, never shown to the BIU.
        q_pop      = q_nonempty && (!head_live || biu_rdy_i);

        live_d = live_q & ~flush_hit;
        if (wr_ok) begin
            live_d[tail_q] = !wr_cancel;
        end

        head_d = q_pop ? head_q + QAW'(1) : head_q;
        tail_d = wr_ok ? tail_q + QAW'(1) : tail_q;
        case ({wr_ok, q_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wack_q  <= 1'b0;
        end else begin
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wack_q  <= wr_ok;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            req_mem_q[tail_q] <= req_i;
        end
    end

    // Full is flagged one entry early so the core's registered strobe always fits.
    assign req_full_o = (count_q >= CntAlmost);
    assign req_wack_o = wack_q;
    assign biu_v_o    = head_valid;
    assign biu_req_o  = head_valid ? req_mem_q[head_q] : '0;

    logic [RESP_W-1:0] resp_data;
    logic              resp_full;
    logic              resp_empty;

    rfphoenix_fwft_fifo #(
        .Width (RESP_W),
        .Depth (RDEPTH)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (biu_resp_wr_i),
        .data_i  (biu_resp_i),
        .pop_i   (resp_rd_i),
        .data_o  (resp_data),
        .full_o  (resp_full),
        .empty_o (resp_empty),
        .ovf_o   (ovf_o)
    );

    logic unused_resp_full;
    assign unused_resp_full = resp_full;

    assign resp_o       = resp_data;
    assign resp_empty_o = resp_empty;
    assign resp_v_o     = !resp_empty;

endmodule

// File: tb/tb_rfphoenix_memreq_queue.sv
// Directed bench for rfphoenix_memreq_queue: request and response scoreboards checked
// with immediate assertions.
module tb_rfphoenix_memreq_queue;
    import rfphoenix_memreq_queue_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_i;
    sMemoryRequest       req_i;
    logic                req_wr_i;
    logic                req_full_o;
    logic                req_wack_o;
    logic                flush_i;
    logic [THREAD_W-1:0] flush_thread_i;
    sMemoryRequest       biu_req_o;
    logic                biu_v_o;
    logic                biu_rdy_i;
    sMemoryResponse      biu_resp_i;
    logic                biu_resp_wr_i;
    sMemoryResponse      resp_o;
    logic                resp_v_o;
    logic                resp_empty_o;
    logic                resp_rd_i;
    logic                ovf_o;

    rfphoenix_memreq_queue dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .req_wr_i       (req_wr_i),
        .req_full_o     (req_full_o),
        .req_wack_o     (req_wack_o),
        .flush_i        (flush_i),
        .flush_thread_i (flush_thread_i),
        .biu_req_o      (biu_req_o),
        .biu_v_o        (biu_v_o),
        .biu_rdy_i      (biu_rdy_i),
        .biu_resp_i     (biu_resp_i),
        .biu_resp_wr_i  (biu_resp_wr_i),
        .resp_o         (resp_o),
        .resp_v_o       (resp_v_o),
        .resp_empty_o   (resp_empty_o),
        .resp_rd_i      (resp_rd_i),
        .ovf_o          (ovf_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_issued = 0;
    int iss0;
    sMemoryRequest  req_sb [$];
    sMemoryResponse resp_sb [$];
    sMemoryRequest  mon_exp;
    sMemoryResponse resp_exp;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic sMemoryRequest mk_req(input logic [31:0] adr, input logic [3:0] thr,
                                             input logic [5:0] rid);
        sMemoryRequest r;
        r        = '0;
        r.func   = MR_STORE;
        r.sz     = tetra;
        r.adr    = adr;
        r.dat    = ~adr;
        r.rid    = rid;
        r.step   = 3'd1;
        r.thread = thr;
        return r;
    endfunction

    function automatic sMemoryResponse mk_resp(input logic [5:0] rid);
        sMemoryResponse r;
        r.rid  = rid;
        r.step = 3'd2;
        r.dat  = 32'hA000 + 32'(rid);
        return r;
    endfunction

    // Every handshake the BIU sees must match the next expected request.
    always @(negedge clk) begin
        if (rst_i && biu_v_o && biu_rdy_i) begin
            n_issued++;
            if (req_sb.size() == 0) begin
                check("issue_unexpected", 128'(biu_v_o), 128'(0));
            end else begin
                mon_exp = req_sb.pop_front();
                check("biu_req", 128'(biu_req_o), 128'(mon_exp));
            end
        end
    end

    initial begin
        rst_i          = 1'b0;
        req_i          = '0;
        req_wr_i       = 1'b0;
        flush_i        = 1'b0;
        flush_thread_i = '0;
        biu_rdy_i      = 1'b0;
        biu_resp_i     = '0;
        biu_resp_wr_i  = 1'b0;
        resp_rd_i      = 1'b0;

        // Reset held with a write strobe active
        req_i    = mk_req(32'h0DEAD, 4'd0, 6'd0);
        req_wr_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_biu_v", 128'(biu_v_o), 128'(0));
            check("rst_wack", 128'(req_wack_o), 128'(0));
            check("rst_resp_empty", 128'(resp_empty_o), 128'(1));
        end
        check("rst_full", 128'(req_full_o), 128'(0));
        check("rst_biu_req", 128'(biu_req_o), 128'(0));
        check("rst_ovf", 128'(ovf_o), 128'(0));
        check("rst_resp_v", 128'(resp_v_o), 128'(0));
        req_wr_i = 1'b0;
        rst_i    = 1'b1;
        step();

        // Fill with BIU stalled, then drain in order
        for (int i = 0; i < 8; i++) begin
            req_i    = mk_req(32'h100 + 32'(i * 16), 4'd0, 6'(i));
            req_wr_i = 1'b1;
            req_sb.push_back(req_i);
            step();
            check("fill_wack", 128'(req_wack_o), 128'(1));
            check("fill_full", 128'(req_full_o), 128'(i >= 6));
        end
        req_i = mk_req(32'h180, 4'd0, 6'd8);
        step();
        req_wr_i = 1'b0;
        check("drop_wack", 128'(req_wack_o), 128'(0));
        check("drop_full", 128'(req_full_o), 128'(1));
        biu_rdy_i = 1'b1;
        iss0 = n_issued;
        repeat (8) step();
        check("drain_count", 128'(n_issued - iss0), 128'(8));
        check("drain_v", 128'(biu_v_o), 128'(0));
        check("drain_sb", 128'(req_sb.size()), 128'(0));
        biu_rdy_i = 1'b0;

        // Flush thread 1; head handed off in the flush cycle still goes out
        for (int i = 0; i < 4; i++) begin
            req_i    = mk_req(32'h200 + 32'(i * 16), (i == 1) ? 4'd2 : (i == 3) ? 4'd3 : 4'd1,
                              6'(i));
            req_wr_i = 1'b1;
            if (i != 2) req_sb.push_back(req_i);
            step();
        end
        req_i          = mk_req(32'h280, 4'd1, 6'd4);
        flush_i        = 1'b1;
        flush_thread_i = 4'd1;
        biu_rdy_i      = 1'b1;
        iss0           = n_issued;
        step();
        check("flush_wack", 128'(req_wack_o), 128'(1));
        flush_i  = 1'b0;
        req_wr_i = 1'b0;
        repeat (5) step();
        check("flush_issued", 128'(n_issued - iss0), 128'(3));
        check("flush_sb", 128'(req_sb.size()), 128'(0));
        check("flush_v", 128'(biu_v_o), 128'(0));

        // Back-to-back throughput with BIU always ready
        iss0 = n_issued;
        for (int i = 0; i < 6; i++) begin
            req_i    = mk_req(32'h300 + 32'(i * 16), 4'd5, 6'(i));
            req_wr_i = 1'b1;
            req_sb.push_back(req_i);
            step();
            check("thru_wack", 128'(req_wack_o), 128'(1));
            check("thru_v", 128'(biu_v_o), 128'(1));
            check("thru_full", 128'(req_full_o), 128'(0));
        end
        req_wr_i = 1'b0;
        step();
        check("thru_issued", 128'(n_issued - iss0), 128'(6));
        check("thru_v_end", 128'(biu_v_o), 128'(0));
        biu_rdy_i = 1'b0;

        // Response FIFO: overfill, then push+pop while full
        for (int i = 0; i < 9; i++) begin
            biu_resp_i    = mk_resp(6'(i));
            biu_resp_wr_i = 1'b1;
            if (i < 8) resp_sb.push_back(biu_resp_i);
            step();
            check("resp_ovf", 128'(ovf_o), 128'(i == 8));
            check("resp_v", 128'(resp_v_o), 128'(1));
        end
        biu_resp_i = mk_resp(6'd9);
        resp_rd_i  = 1'b1;
        resp_exp   = resp_sb.pop_front();
        check("resp_head_full", 128'(resp_o), 128'(resp_exp));
        resp_sb.push_back(biu_resp_i);
        step();
        biu_resp_wr_i = 1'b0;
        check("resp_ovf_pp", 128'(ovf_o), 128'(1));
        for (int i = 0; i < 8; i++) begin
            check("drain_resp_v", 128'(resp_v_o), 128'(1));
            resp_exp = resp_sb.pop_front();
            check("drain_resp", 128'(resp_o), 128'(resp_exp));
            step();
        end
        check("resp_empty", 128'(resp_empty_o), 128'(1));
        check("resp_v_end", 128'(resp_v_o), 128'(0));
        step();
        check("resp_rd_empty", 128'(resp_empty_o), 128'(1));
        check("resp_ovf_sticky", 128'(ovf_o), 128'(1));
        resp_rd_i = 1'b0;

        // Reset mid-flight discards everything
        for (int i = 0; i < 4; i++) begin
            req_i         = mk_req(32'h400 + 32'(i * 16), 4'd6, 6'(i));
            req_wr_i      = 1'b1;
            biu_resp_i    = mk_resp(6'(20 + i));
            biu_resp_wr_i = (i < 3);
            step();
        end
        req_wr_i      = 1'b0;
        biu_resp_wr_i = 1'b0;
        check("mid_v_pre", 128'(biu_v_o), 128'(1));
        check("mid_resp_pre", 128'(resp_v_o), 128'(1));
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        check("mid_v", 128'(biu_v_o), 128'(0));
        check("mid_resp_empty", 128'(resp_empty_o), 128'(1));
        check("mid_ovf", 128'(ovf_o), 128'(0));
        check("mid_full", 128'(req_full_o), 128'(0));
        biu_rdy_i = 1'b1;
        iss0      = n_issued;
        repeat (4) step();
        check("mid_issued", 128'(n_issued - iss0), 128'(0));
        check("mid_v_end", 128'(biu_v_o), 128'(0));
        check("mid_resp_end", 128'(resp_empty_o), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
